// File: rtl/systolic_wrapper.sv
// FP32 outer-product MAC array: each step multiplies a_lat[i]*b_lat[j] and adds into psum_reg[i][j].
// A step launches when step valid meets step_ready; the result lands one cycle later, so a step is accepted at most every 2 cycles.
module systolic_sa #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_step_valid,
    input  logic        i_k_first,
    input  logic        i_k_last,
    input  logic        i_clear,
    input  logic [31:0] i_a [M],
    input  logic [31:0] i_b [N],
    output logic        o_step_ready,
    output logic        o_out_valid,
    output logic        o_k_last,
    output logic [31:0] o_psum [M][N]
);
    logic [31:0] a_lat [M];
    logic [31:0] b_lat [N];
    logic        k_first_lat;
    logic        k_last_lat;
    logic        pe_out_valid;
    logic        step_ready;
    logic [31:0] pe_psum_in  [M][N];
    logic [31:0] pe_psum_out [M][N];
    logic [31:0] psum_reg    [M][N];

    // Round-to-nearest-even on a 24-bit significand with guard/sticky; tiny results flush to signed zero.
    function automatic logic [31:0] fp_round(input logic s, input logic signed [11:0] e_in,
                                             input logic [23:0] m_in, input logic g, input logic st);
        logic [24:0]        m;
        logic signed [11:0] e;
        m = {1'b0, m_in};
        e = e_in;
        if (g && (st || m_in[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 12'sd1;
        end
        if (e <= 12'sd0)   return {s, 31'd0};
        if (e >= 12'sd255) return {s, 8'hff, 23'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [11:0] e;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        if (a_nan) return a | 32'h0040_0000;
        if (b_nan) return b | 32'h0040_0000;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7fc0_0000;
        if (a_inf || b_inf) return {s, 8'hff, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
        if (p[47]) return fp_round(s, e + 12'sd1, p[47:24], p[23], |p[22:0]);
        return fp_round(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [26:0]        mx, my, nrm;
        logic [49:0]        sh;
        logic [27:0]        sum;
        logic [7:0]         d;
        logic [4:0]         lz;
        logic               found;
        logic signed [11:0] e;
        logic               a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
        if (a_nan) return a | 32'h0040_0000;
        if (b_nan) return b | 32'h0040_0000;
        if (a_inf && b_inf && (a[31] != b[31])) return 32'h7fc0_0000;
        if (a_inf) return a;
        if (b_inf) return b;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'd0};
        // Beyond 30 positions the smaller operand only contributes a sticky bit.
        if (d > 8'd30) begin
            my = 27'd1;
        end else begin
            sh = {1'b1, y[22:0], 26'd0} >> d;
            my = {sh[49:24], |sh[23:0]};
        end
        sum = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        if (sum == 28'd0) return 32'd0;
        e = $signed({4'd0, x[30:23]});
        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            e   = e + 12'sd1;
        end else begin
            lz    = 5'd0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found && sum[i]) begin
                    lz    = 5'(26 - i);
                    found = 1'b1;
                end
            end
            nrm = sum[26:0] << lz;
            e   = e - $signed({7'd0, lz});
        end
        return fp_round(x[31], e, nrm[26:3], nrm[2], |nrm[1:0]);
    endfunction

    assign step_ready   = ~pe_out_valid;
    assign o_step_ready = step_ready;
    assign o_out_valid  = pe_out_valid;
    assign o_k_last     = k_last_lat;
    assign o_psum       = psum_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pe_out_valid <= 1'b0;
            k_first_lat  <= 1'b0;
            k_last_lat   <= 1'b0;
            for (int i = 0; i < M; i++) a_lat[i] <= '0;
            for (int j = 0; j < N; j++) b_lat[j] <= '0;
        end else begin
            pe_out_valid <= i_step_valid;
            if (i_step_valid) begin
                a_lat       <= i_a;
                b_lat       <= i_b;
                k_first_lat <= i_k_first;
                k_last_lat  <= i_k_last;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                pe_psum_in[i][j]  = k_first_lat ? 32'd0 : psum_reg[i][j];
                pe_psum_out[i][j] = fp_add(pe_psum_in[i][j], fp_mul(a_lat[i], b_lat[j]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || i_clear) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) psum_reg[i][j] <= '0;
        end else if (pe_out_valid) begin
            psum_reg <= pe_psum_out;
        end
    end
endmodule

// FP32 C = A*B engine: start/busy/done control around the MAC array; a K-step job finishes 2K cycles after start.
// No stall path: the feeder must present data whenever the array is ready; start is ignored while busy.
module systolic_wrapper #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        done_clear,
    input  logic [15:0] K,
    input  logic [31:0] a_row_in [M],
    input  logic [31:0] b_col_in [N],
    output logic        busy,
    output logic        done,
    output logic [31:0] c_out   [M][N],
    output logic        c_valid [M][N]
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_k;
    logic [15:0] k_idx;
    logic        r_done;
    logic        r_c_valid;
    logic        step_valid;
    logic        w_step_ready, w_out_valid, w_k_last;
    logic        w_accept, w_finish, w_zero_job;
    logic [31:0] w_psum [M][N];

    assign busy       = (r_state == S_RUN);
    assign done       = r_done;
    assign step_valid = busy && (k_idx < r_k) && w_step_ready;
    assign c_out      = w_psum;

    always_comb begin
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) c_valid[i][j] = r_c_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_zero_job  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (K != 16'd0) w_state_nxt = S_RUN;
                    else            w_zero_job  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_out_valid && w_k_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Completion beats done_clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_k       <= '0;
            k_idx     <= '0;
            r_done    <= 1'b0;
            r_c_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_k   <= K;
                k_idx <= '0;
            end else if (step_valid) begin
                k_idx <= k_idx + 16'd1;
            end
            if (w_finish || w_zero_job)        r_done <= 1'b1;
            else if (w_accept || done_clear)   r_done <= 1'b0;
            if (w_finish || w_zero_job)        r_c_valid <= 1'b1;
            else if (w_accept)                 r_c_valid <= 1'b0;
        end
    end

    systolic_sa #(.M(M), .N(N)) u_sa (
        .clk          (clk),
        .rst          (rst),
        .i_step_valid (step_valid),
        .i_k_first    (k_idx == 16'd0),
        .i_k_last     (k_idx == (r_k - 16'd1)),
        .i_clear      (w_zero_job),
        .i_a          (a_row_in),
        .i_b          (b_col_in),
        .o_step_ready (w_step_ready),
        .o_out_valid  (w_out_valid),
        .o_k_last     (w_k_last),
        .o_psum       (w_psum)
    );
endmodule

// File: tb/tb_systolic_wrapper.sv
// Bench for systolic_wrapper: directed and random FP32 jobs checked against a real-arithmetic model.
module tb_systolic_wrapper;
    localparam int M = 8;
    localparam int N = 8;
    localparam int KMAX = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done_clear = 1'b0;
    logic [15:0] K = 16'd0;
    logic [31:0] a_row_in [M];
    logic [31:0] b_col_in [N];
    logic        busy, done;
    logic [31:0] c_out   [M][N];
    logic        c_valid [M][N];

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] ga [M][KMAX];
    logic [31:0] gb [KMAX][N];
    logic [31:0] exp_c [M][N];
    int          launch_cyc [KMAX];
    logic        obs_first [KMAX];
    logic        obs_last  [KMAX];
    logic [15:0] kidx_before, kidx_after;

    always #5 clk = ~clk;

    systolic_wrapper #(.M(M), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .done_clear (done_clear),
        .K          (K),
        .a_row_in   (a_row_in),
        .b_col_in   (b_col_in),
        .busy       (busy),
        .done       (done),
        .c_out      (c_out),
        .c_valid    (c_valid)
    );

    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] de;
        de = {3'b0, x[30:23]} + 11'd896;
        if (x[30:23] == 8'd0)       d = {x[31], 63'd0};
        else if (x[30:23] == 8'hff) d = {x[31], 11'h7ff, x[22:0], 29'd0};
        else                        d = {x[31], de, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [24:0] m;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7ff) return (d[51:0] != 52'd0) ? 32'h7fc00000 : {d[63], 8'hff, 23'd0};
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hff, 23'd0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        e = 8'($urandom_range(140, 110));
        if ($urandom_range(9, 0) == 0) return {r[31], 31'd0};
        return {r[31], e, r[22:0]};
    endfunction

    // C[i][j] = sum over k of round(A*B), each add rounded, starting from +0.
    task automatic model_job(input int k);
        logic [31:0] p, s;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 32'd0;
                for (int kk = 0; kk < k; kk++) begin
                    p = r2f(f2r(ga[i][kk]) * f2r(gb[kk][j]));
                    s = r2f(((kk == 0) ? 0.0 : f2r(s)) + f2r(p));
                end
                exp_c[i][j] = s;
            end
        end
    endtask

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < M; i++) ga[i][kk] = rand_fp();
            for (int j = 0; j < N; j++) gb[kk][j] = rand_fp();
        end
    endtask

    task automatic drive_step(input int s);
        for (int i = 0; i < M; i++) a_row_in[i] = ga[i][s];
        for (int j = 0; j < N; j++) b_col_in[j] = gb[s][j];
    endtask

    // Runs one job; cycles counts edges after the start-sampling edge until done is seen.
    task automatic run_job(input int k, input int poke_at, output int cycles, output int steps);
        int s;
        s = 0;
        @(negedge clk);
        K = 16'(k);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (!done && cycles < 4 * k + 20) begin
            if (dut.u_sa.pe_out_valid && s > 0 && s <= KMAX) begin
                obs_first[s-1] = dut.u_sa.k_first_lat;
                obs_last[s-1]  = dut.u_sa.k_last_lat;
            end
            if (busy && dut.u_sa.step_ready && s < k) drive_step(s);
            if (dut.step_valid) begin
                if (s < KMAX) launch_cyc[s] = cycles;
                s++;
            end
            start = (cycles == poke_at);
            if (cycles == poke_at) begin
                K = 16'd1;
                kidx_before = dut.k_idx;
            end
            if (cycles == poke_at + 1) kidx_after = dut.k_idx;
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        K = 16'(k);
        steps = s;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_chk++; if (dut.k_idx !== 16'd0) begin n_err++; $display("FAIL reset_k_idx: got %0d expected 0", dut.k_idx); end
        n_chk++; if (dut.u_sa.step_ready !== 1'b1) begin n_err++; $display("FAIL reset_step_ready: got %b expected 1", dut.u_sa.step_ready); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== 32'd0 || c_valid[i][j] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_cell[%0d][%0d]: got %h/%b expected 00000000/0", i, j, c_out[i][j], c_valid[i][j]);
                end
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] aval [4];
        logic [31:0] bval [4];
        int cyc, st;
        aval = '{32'h3f800000, 32'h40000000, 32'h3f000000, 32'h40400000};
        bval = '{32'h3f800000, 32'h3f000000, 32'h40000000, 32'h40400000};
        for (int kk = 0; kk < 4; kk++) begin
            for (int i = 0; i < M; i++) ga[i][kk] = aval[(kk + i) % 4];
            for (int j = 0; j < N; j++) gb[kk][j] = bval[(kk + j) % 4];
        end
        model_job(4);
        run_job(4, -10, cyc, st);
        n_chk++; if (st !== 4) begin n_err++; $display("FAIL basic_steps: got %0d expected 4", st); end
        n_chk++; if (cyc !== 8 || done !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %0d cycles done=%b expected 8 done=1", cyc, done); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_chk++; if (c_out[0][0] !== 32'h41400000) begin n_err++; $display("FAIL basic_c00: got %h expected 41400000", c_out[0][0]); end
        n_chk++; if (c_out[0][1] !== 32'h41100000) begin n_err++; $display("FAIL basic_c01: got %h expected 41100000", c_out[0][1]); end
        n_chk++; if (c_out[1][0] !== 32'h41340000) begin n_err++; $display("FAIL basic_c10: got %h expected 41340000", c_out[1][0]); end
        for (int s = 0; s < 4; s++) begin
            n_chk++;
            if (obs_first[s] !== (s == 0) || obs_last[s] !== (s == 3)) begin
                n_err++;
                $display("FAIL basic_kflags[%0d]: got first=%b last=%b expected first=%b last=%b", s, obs_first[s], obs_last[s], s == 0, s == 3);
            end
            if (s > 0) begin
                n_chk++;
                if (launch_cyc[s] - launch_cyc[s-1] !== 2) begin
                    n_err++;
                    $display("FAIL basic_spacing[%0d]: got %0d expected 2", s, launch_cyc[s] - launch_cyc[s-1]);
                end
            end
        end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== exp_c[i][j] || c_valid[i][j] !== 1'b1) begin
                    n_err++;
                    $display("FAIL basic_cell[%0d][%0d]: got %h/%b expected %h/1", i, j, c_out[i][j], c_valid[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    task automatic test_done_clear();
        int cyc, st;
        @(negedge clk);
        done_clear = 1'b1;
        @(negedge clk);
        done_clear = 1'b0;
        n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL clear_done: got %b expected 0", done); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== exp_c[i][j] || c_valid[i][j] !== 1'b1) begin
                    n_err++;
                    $display("FAIL clear_cell[%0d][%0d]: got %h/%b expected %h/1", i, j, c_out[i][j], c_valid[i][j], exp_c[i][j]);
                end
            end
        end
        run_job(4, -10, cyc, st);
        n_chk++; if (done !== 1'b1 || cyc !== 8) begin n_err++; $display("FAIL rerun_done: got done=%b at %0d expected 1 at 8", done, cyc); end
        n_chk++; if (c_out[0][0] !== 32'h41400000) begin n_err++; $display("FAIL rerun_c00: got %h expected 41400000", c_out[0][0]); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== exp_c[i][j]) begin
                    n_err++;
                    $display("FAIL rerun_cell[%0d][%0d]: got %h expected %h", i, j, c_out[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, st;
        fill_random(6);
        model_job(6);
        run_job(6, 3, cyc, st);
        n_chk++; if (kidx_after < kidx_before || kidx_before == 16'd0) begin n_err++; $display("FAIL busy_start_kidx: got %0d after %0d expected no reset", kidx_after, kidx_before); end
        n_chk++; if (st !== 6 || cyc !== 12 || done !== 1'b1) begin n_err++; $display("FAIL busy_start_job: got steps=%0d cycles=%0d done=%b expected 6/12/1", st, cyc, done); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== exp_c[i][j]) begin
                    n_err++;
                    $display("FAIL busy_start_cell[%0d][%0d]: got %h expected %h", i, j, c_out[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    task automatic test_k_zero();
        int cyc, st;
        run_job(0, -10, cyc, st);
        n_chk++; if (done !== 1'b1 || cyc !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL kzero_done: got done=%b at %0d busy=%b expected 1 at 0 busy=0", done, cyc, busy); end
        n_chk++; if (st !== 0) begin n_err++; $display("FAIL kzero_steps: got %0d expected 0", st); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== 32'd0 || c_valid[i][j] !== 1'b1) begin
                    n_err++;
                    $display("FAIL kzero_cell[%0d][%0d]: got %h/%b expected 00000000/1", i, j, c_out[i][j], c_valid[i][j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int s, cyc, st;
        fill_random(5);
        @(negedge clk);
        K = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = 0;
        cyc = 0;
        while (cyc < 40 && !(s == 2 && !dut.u_sa.pe_out_valid)) begin
            if (busy && dut.u_sa.step_ready && s < 5) drive_step(s);
            if (dut.step_valid) s++;
            @(negedge clk);
            cyc++;
        end
        n_chk++; if (s !== 2 || busy !== 1'b1) begin n_err++; $display("FAIL midrst_setup: got steps=%0d busy=%b expected 2/1", s, busy); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0/0", busy, done); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (dut.u_sa.psum_reg[i][j] !== 32'd0 || c_valid[i][j] !== 1'b0) begin
                    n_err++;
                    $display("FAIL midrst_cell[%0d][%0d]: got %h/%b expected 00000000/0", i, j, dut.u_sa.psum_reg[i][j], c_valid[i][j]);
                end
            end
        end
        repeat (3) @(negedge clk);
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_quiet: got done=%b busy=%b expected 0/0", done, busy); end
        fill_random(3);
        model_job(3);
        run_job(3, -10, cyc, st);
        n_chk++; if (done !== 1'b1 || cyc !== 6) begin n_err++; $display("FAIL midrst_next_done: got %b at %0d expected 1 at 6", done, cyc); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (c_out[i][j] !== exp_c[i][j]) begin
                    n_err++;
                    $display("FAIL midrst_next_cell[%0d][%0d]: got %h expected %h", i, j, c_out[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    task automatic test_random();
        int k, cyc, st;
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(12, 1);
            fill_random(k);
            model_job(k);
            run_job(k, -10, cyc, st);
            n_chk++;
            if (st !== k || cyc !== 2 * k || done !== 1'b1) begin
                n_err++;
                $display("FAIL rand%0d_job: got steps=%0d cycles=%0d done=%b expected %0d/%0d/1", r, st, cyc, done, k, 2 * k);
            end
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    n_chk++;
                    if (c_out[i][j] !== exp_c[i][j]) begin
                        n_err++;
                        $display("FAIL rand%0d_cell[%0d][%0d]: got %h expected %h", r, i, j, c_out[i][j], exp_c[i][j]);
                    end
                end
            end
        end
    endtask

    task automatic test_special();
        int cyc, st;
        fill_random(2);
        ga[0][0] = 32'h7f800000;
        ga[1][0] = 32'h00000001;
        ga[2][0] = 32'h7fc00001;
        ga[3][0] = 32'h7f000000;
        ga[4][0] = 32'h00800000;
        gb[0][1] = 32'h00000000;
        gb[0][2] = 32'h3f000000;
        gb[0][3] = 32'h43000000;
        model_job(2);
        run_job(2, -10, cyc, st);
        n_chk++; if (done !== 1'b1 || cyc !== 4) begin n_err++; $display("FAIL special_done: got %b at %0d expected 1 at 4", done, cyc); end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                n_chk++;
                if (is_nan(exp_c[i][j]) ? !is_nan(c_out[i][j]) : (c_out[i][j] !== exp_c[i][j])) begin
                    n_err++;
                    $display("FAIL special_cell[%0d][%0d]: got %h expected %h", i, j, c_out[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < M; i++) a_row_in[i] = 32'd0;
        for (int j = 0; j < N; j++) b_col_in[j] = 32'd0;
        test_reset();
        test_basic();
        test_done_clear();
        test_start_while_busy();
        test_k_zero();
        test_reset_mid_job();
        test_random();
        test_special();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
